// File: rtl/adf_sweep_ctrl.sv
// Frequency-sweep sequencer feeding the ADF PLL serial driver: steps a code from f_start to f_stop.
// Optional SWEEP_TIMEOUT_EN adds a busy-handshake timeout (err[1]) and the TIMEOUT parameter.
module adf_sweep_ctrl #(
  parameter int DW      = 9,
  parameter int DWELL_W = 24,
  parameter int WR_HOLD = 128
`ifdef SWEEP_TIMEOUT_EN
  , parameter int TIMEOUT = 4096
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DW-1:0]      f_start,
  input  logic [DW-1:0]      f_stop,
  input  logic [DW-1:0]      f_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               cont,
  input  logic               tx_idle,
  output logic [DW-1:0]      datain,
  output logic               wrsig,
  output logic               sweep_busy,
  output logic               sweep_done,
  output logic [1:0]         err,
  output logic [15:0]        point_cnt,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ASSERT    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DWELL     = 3'd4,
    S_NEXT      = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  localparam int HW = $clog2(WR_HOLD + 1);

  // Handshake: the driver owns tx_idle (high = shifting). A write is one wrsig
  // pulse of WR_HOLD cycles with datain stable; completion is tx_idle rising then falling.
  state_t               state_q, state_d;
  logic [DW-1:0]        datain_d;
  logic                 wrsig_d, done_d;
  logic [1:0]           err_d;
  logic [15:0]          pcnt_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DW-1:0]        sh_start_q, sh_start_d, sh_stop_q, sh_stop_d, sh_step_q, sh_step_d;
  logic [DWELL_W-1:0]   sh_dwell_q, sh_dwell_d;
  logic                 sh_cont_q, sh_cont_d;
  logic [DW:0]          nxt;

`ifdef SWEEP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_q, wait_d;
`endif

  assign dbg_state = state_q;
  assign nxt = {1'b0, datain} + {1'b0, sh_step_q};

  always_comb begin
    state_d    = state_q;
    datain_d   = datain;
    wrsig_d    = wrsig;
    done_d     = 1'b0;
    err_d      = err;
    pcnt_d     = point_cnt;
    hold_d     = hold_q;
    dwell_d    = dwell_q;
    sh_start_d = sh_start_q;
    sh_stop_d  = sh_stop_q;
    sh_step_d  = sh_step_q;
    sh_dwell_d = sh_dwell_q;
    sh_cont_d  = sh_cont_q;
`ifdef SWEEP_TIMEOUT_EN
    wait_d     = wait_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          sh_start_d = f_start;
          sh_stop_d  = f_stop;
          sh_step_d  = f_step;
          sh_dwell_d = dwell;
          sh_cont_d  = cont;
          err_d      = 2'b00;
          pcnt_d     = 16'd0;
          if (f_start > f_stop) begin
            err_d[0] = 1'b1;
            state_d  = S_DONE;
          end else begin
            datain_d = f_start;
            wrsig_d  = 1'b1;
            hold_d   = '0;
            state_d  = S_ASSERT;
          end
        end
      end
      S_ASSERT: begin
        if (hold_q == HW'(WR_HOLD - 1)) begin
          wrsig_d = 1'b0;
          pcnt_d  = point_cnt + 16'd1;
          state_d = S_WAIT_BUSY;
`ifdef SWEEP_TIMEOUT_EN
          wait_d  = TW'(1);
`endif
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_WAIT_BUSY: begin
        if (tx_idle) begin
          state_d = S_WAIT_DONE;
`ifdef SWEEP_TIMEOUT_EN
          wait_d  = TW'(1);
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          err_d[1] = 1'b1;
          state_d  = S_DONE;
        end else begin
          wait_d = wait_q + TW'(1);
`endif
        end
      end
      S_WAIT_DONE: begin
        if (!tx_idle) begin
          dwell_d = sh_dwell_q;
          state_d = S_DWELL;
`ifdef SWEEP_TIMEOUT_EN
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          err_d[1] = 1'b1;
          state_d  = S_DONE;
        end else begin
          wait_d = wait_q + TW'(1);
`endif
        end
      end
      S_DWELL: begin
        if (dwell_q == '0) state_d = S_NEXT;
        else               dwell_d = dwell_q - DWELL_W'(1);
      end
      S_NEXT: begin
        // nxt carries one extra bit so a step past the top code never aliases low
        if ((sh_step_q != '0) && !nxt[DW] && (nxt[DW-1:0] <= sh_stop_q)) begin
          datain_d = nxt[DW-1:0];
          wrsig_d  = 1'b1;
          hold_d   = '0;
          state_d  = S_ASSERT;
        end else if (sh_cont_q) begin
          datain_d = sh_start_q;
          wrsig_d  = 1'b1;
          hold_d   = '0;
          state_d  = S_ASSERT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifndef SWEEP_TIMEOUT_EN
    err_d[1] = 1'b0;
`endif
    // Abort overrides everything: no done pulse, error and count untouched
    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      wrsig_d = 1'b0;
      done_d  = 1'b0;
      err_d   = err;
      pcnt_d  = point_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      datain     <= '0;
      wrsig      <= 1'b0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
      err        <= 2'b00;
      point_cnt  <= 16'd0;
      hold_q     <= '0;
      dwell_q    <= '0;
      sh_start_q <= '0;
      sh_stop_q  <= '0;
      sh_step_q  <= '0;
      sh_dwell_q <= '0;
      sh_cont_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      datain     <= datain_d;
      wrsig      <= wrsig_d;
      sweep_busy <= (state_d != S_IDLE);
      sweep_done <= done_d;
      err        <= err_d;
      point_cnt  <= pcnt_d;
      hold_q     <= hold_d;
      dwell_q    <= dwell_d;
      sh_start_q <= sh_start_d;
      sh_stop_q  <= sh_stop_d;
      sh_step_q  <= sh_step_d;
      sh_dwell_q <= sh_dwell_d;
      sh_cont_q  <= sh_cont_d;
    end
  end

`ifdef SWEEP_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end
`endif

endmodule

// File: tb/tb_adf_sweep_ctrl.sv
// Directed bench for adf_sweep_ctrl with a behavioural driver model and an expected-code queue.
module tb_adf_sweep_ctrl;
  localparam int DW = 9;
  localparam int DWELL_W = 24;
  localparam int WR_HOLD = 128;

  logic               clk, rst, start, stop, cont, tx_idle;
  logic [DW-1:0]      f_start, f_stop, f_step, datain;
  logic [DWELL_W-1:0] dwell;
  logic               wrsig, sweep_busy, sweep_done;
  logic [1:0]         err;
  logic [15:0]        point_cnt;
  logic [2:0]         dbg_state;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  int  wr_cnt = 0;
  int  done_cnt = 0;
  bit  expect_cut = 0;
  bit  drv_en = 1;

  adf_sweep_ctrl #(
    .DW(DW), .DWELL_W(DWELL_W), .WR_HOLD(WR_HOLD)
`ifdef SWEEP_TIMEOUT_EN
    , .TIMEOUT(100)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .cont(cont), .tx_idle(tx_idle), .datain(datain), .wrsig(wrsig),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done), .err(err),
    .point_cnt(point_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver model: tx_idle high 40 cycles after a wrsig rise, for 1700 cycles
  initial begin
    logic prev;
    prev = 1'b0;
    tx_idle = 1'b0;
    forever begin
      @(negedge clk);
      if (drv_en && wrsig === 1'b1 && !prev) begin
        repeat (40) @(negedge clk);
        tx_idle = 1'b1;
        repeat (1700) @(negedge clk);
        tx_idle = 1'b0;
      end
      prev = wrsig;
    end
  end

  // scoreboard monitor: pops an expected code on every wrsig rise
  initial begin
    logic prev_wr;
    int   len;
    prev_wr = 1'b0;
    len = 0;
    forever begin
      @(negedge clk);
      if (sweep_done === 1'b1) done_cnt++;
      if (wrsig === 1'b1 && !prev_wr) begin
        wr_cnt++;
        len = 1;
        if (exp_q.size() == 0) chk("unexpected_write", 32'(datain), 32'hFFFF);
        else                   chk("datain", 32'(datain), 32'(exp_q.pop_front()));
      end else if (wrsig === 1'b1) begin
        len++;
      end else if (prev_wr) begin
        if (expect_cut) expect_cut = 0;
        else            chk("wr_len", 32'(len), 32'(WR_HOLD));
      end
      prev_wr = wrsig;
    end
  end

  task automatic do_start(input int fs, input int fe, input int st, input int dw, input bit c);
    @(negedge clk);
    f_start = DW'(fs);
    f_stop  = DW'(fe);
    f_step  = DW'(st);
    dwell   = DWELL_W'(dw);
    cont    = c;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sweep_done !== 1'b1 && n < budget);
    chk(tag, 32'(sweep_done), 32'd1);
  endtask

  task automatic wait_writes(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (wr_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(wr_cnt >= target), 32'd1);
  endtask

  initial begin
    int d0, w0, n;
    rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    repeat (3) @(negedge clk);
    chk("rst_datain", 32'(datain), 32'd0);
    chk("rst_wrsig", 32'(wrsig), 32'd0);
    chk("rst_busy", 32'(sweep_busy), 32'd0);
    chk("rst_done", 32'(sweep_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_pcnt", 32'(point_cnt), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // one-shot 10..14 step 2
    d0 = done_cnt; w0 = wr_cnt;
    exp_q.push_back(9'd10); exp_q.push_back(9'd12); exp_q.push_back(9'd14);
    do_start(10, 14, 2, 5, 1'b0);
    chk("os_wrsig_rise", 32'(wrsig), 32'd1);
    chk("os_busy", 32'(sweep_busy), 32'd1);
    wait_done("os_done", 20000);
    chk("os_err", 32'(err), 32'd0);
    chk("os_pcnt", 32'(point_cnt), 32'd3);
    @(negedge clk);
    chk("os_done_pulse_len", 32'(sweep_done), 32'd0);
    chk("os_idle", 32'(sweep_busy), 32'd0);
    chk("os_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("os_writes", 32'(wr_cnt - w0), 32'd3);
    chk("os_q_empty", 32'(exp_q.size()), 32'd0);
    chk("os_datain_hold", 32'(datain), 32'd14);

    // continuous sweep, stop during DWELL of the 5th point
    d0 = done_cnt; w0 = wr_cnt;
    exp_q.push_back(9'd10); exp_q.push_back(9'd12); exp_q.push_back(9'd14);
    exp_q.push_back(9'd10); exp_q.push_back(9'd12);
    do_start(10, 14, 2, 5, 1'b1);
    wait_writes("cont_5_writes", w0 + 5, 12000);
    n = 0;
    while (dbg_state !== 3'd4 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("cont_reach_dwell", 32'(dbg_state), 32'd4);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_busy", 32'(sweep_busy), 32'd0);
    chk("stop_state", 32'(dbg_state), 32'd0);
    repeat (3) @(negedge clk);
    chk("stop_no_done", 32'(done_cnt - d0), 32'd0);
    chk("stop_err", 32'(err), 32'd0);
    chk("stop_pcnt", 32'(point_cnt), 32'd5);
    chk("cont_q_empty", 32'(exp_q.size()), 32'd0);

    // config error
    w0 = wr_cnt;
    do_start(20, 5, 1, 0, 1'b0);
    chk("cfg_done_not_yet", 32'(sweep_done), 32'd0);
    @(negedge clk);
    chk("cfg_done", 32'(sweep_done), 32'd1);
    chk("cfg_err", 32'(err), 32'd1);
    chk("cfg_busy", 32'(sweep_busy), 32'd0);
    repeat (2) @(negedge clk);
    chk("cfg_no_write", 32'(wr_cnt - w0), 32'd0);

    // overflow near the top code
    exp_q.push_back(9'd500); exp_q.push_back(9'd508);
    do_start(500, 511, 8, 0, 1'b0);
    chk("ovf_err_cleared", 32'(err), 32'd0);
    wait_done("ovf_done", 12000);
    chk("ovf_pcnt", 32'(point_cnt), 32'd2);
    chk("ovf_q_empty", 32'(exp_q.size()), 32'd0);

    // zero step
    exp_q.push_back(9'd7);
    do_start(7, 7, 0, 3, 1'b0);
    wait_done("zstep_done", 6000);
    chk("zstep_pcnt", 32'(point_cnt), 32'd1);
    chk("zstep_q_empty", 32'(exp_q.size()), 32'd0);

`ifdef SWEEP_TIMEOUT_EN
    drv_en = 0;
    exp_q.push_back(9'd3);
    do_start(3, 3, 1, 0, 1'b0);
    n = 0;
    while (wrsig === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sweep_done !== 1'b1 && n < 1000);
    chk("to_latency", 32'(n), 32'd100);
    chk("to_err", 32'(err), 32'd2);
    drv_en = 1;
    repeat (3) @(negedge clk);
`endif

    // reset during ASSERT
    exp_q.push_back(9'd10);
    expect_cut = 1;
    do_start(10, 14, 2, 5, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_wrsig", 32'(wrsig), 32'd0);
    chk("arst_busy", 32'(sweep_busy), 32'd0);
    chk("arst_datain", 32'(datain), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    n = 0;
    while (tx_idle === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("arst_stays_idle", 32'(dbg_state), 32'd0);

    // start while busy is ignored
    w0 = wr_cnt;
    exp_q.push_back(9'd10); exp_q.push_back(9'd12); exp_q.push_back(9'd14);
    do_start(10, 14, 2, 5, 1'b0);
    wait_writes("busy_3rd_point", w0 + 3, 8000);
    do_start(0, 100, 1, 0, 1'b1);
    wait_done("busy_done", 6000);
    chk("busy_pcnt", 32'(point_cnt), 32'd3);
    chk("busy_datain", 32'(datain), 32'd14);
    chk("busy_q_empty", 32'(exp_q.size()), 32'd0);
    repeat (5) @(negedge clk);
    chk("busy_no_restart", 32'(sweep_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adf_sweep_ctrl.md
# adf_sweep_ctrl

Frequency-sweep sequencer upstream of the ADF PLL serial driver. It steps a 9-bit frequency code from a start value to a stop value. For each point it presents `datain`, raises a `wrsig` write strobe, waits for the driver's busy/idle handshake, then dwells a programmable time before moving on. One-shot and continuous (wrapping) sweeps are supported, plus abort.

## Interface
- `DW`, default 9: frequency code width; matches driver `datain`.
- `DWELL_W`, default 24: dwell counter width.
- `WR_HOLD`, default 128: cycles `wrsig` is held high. Must be at least 2 driver `clkout` periods (driver `clkout` = `clk`/50).
- `TIMEOUT`, default 4096: busy-wait limit in cycles (only with `SWEEP_TIMEOUT_EN`).
- `clk`, input, 1: system clock, the same clock that feeds the driver.
- `rst`, input, 1: asynchronous reset, active-high.
- `start`, input, 1: single-cycle start request. Honoured only in IDLE.
- `stop`, input, 1: abort request.
- `f_start`, input, DW: first frequency code.
- `f_stop`, input, DW: last frequency code (inclusive).
- `f_step`, input, DW: increment per point.
- `dwell`, input, DWELL_W: hold cycles after each completed write.
- `cont`, input, 1: 1 = wrap to `f_start` after the last point; 0 = one-shot.
- `tx_idle`, input, 1: driver status, high = shifting, low = free.
- `datain`, output, DW: frequency code to the driver.
- `wrsig`, output, 1: write strobe to the driver.
- `sweep_busy`, output, 1: high in every state except IDLE.
- `sweep_done`, output, 1: one-cycle pulse when a one-shot sweep ends or a config error is detected.
- `err`, output, 2: sticky error code. Bit0 = config error; bit1 = handshake timeout. Cleared on the next accepted `start`.
- `point_cnt`, output, 16: points written since the last `start`; wraps modulo 2^16.

## Operation
- States:
  - IDLE
  - ASSERT
  - WAIT_BUSY
  - WAIT_DONE
  - DWELL
  - NEXT
  - DONE
- Reset: state IDLE; all outputs 0; shadow registers 0.
- IDLE + `start` (and `stop` = 0): latch `f_start`, `f_stop`, `f_step`, `dwell`, `cont` into shadow registers and clear `err` and `point_cnt`.
  - If `f_start` > `f_stop`: set err[0] and go to DONE. No write is issued.
  - Otherwise: `datain` <= `f_start`, `wrsig` <= 1, go to ASSERT.
- ASSERT: hold `wrsig` = 1 for exactly WR_HOLD cycles, then `wrsig` <= 0, `point_cnt`++, go to WAIT_BUSY.
- WAIT_BUSY: wait for `tx_idle` = 1, then go to WAIT_DONE.
- WAIT_DONE: wait for `tx_idle` = 0, load the dwell counter with the shadow `dwell`, go to DWELL.
- DWELL: decrement the counter to 0, then go to NEXT. With `dwell` = 0, DWELL lasts 1 cycle.
- NEXT: compute `nxt` = cur + step in DW+1 bits.
  - If step != 0, no carry and `nxt` <= `f_stop`: `datain` <= `nxt`, go to ASSERT.
  - Else, if cont: `datain` <= shadow `f_start`, go to ASSERT.
  - Else: go to DONE.
- DONE: `sweep_done` = 1 for one cycle, then IDLE. `datain` keeps its last value.
- `stop` in any non-IDLE state: the next state is IDLE and `wrsig` <= 0. No `sweep_done` pulse; `err` is unchanged.
- `start` while `sweep_busy` is ignored. `start` and `stop` in the same IDLE cycle: `stop` wins and the block stays IDLE.
- `datain` is stable from the `wrsig` rise until the next NEXT state. The driver samples it on its slow clock.

## Timing
- `start` sampled at edge N: `wrsig` = 1 and `datain` valid after edge N. `wrsig` falls after edge N+WR_HOLD.
- Point-to-point period = WR_HOLD + busy-wait + busy time + dwell + 2 cycles, where the 2 cycles are the WAIT_DONE exit and NEXT.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `rst` asserted mid-sweep: outputs go to 0 immediately (asynchronous). The driver finishes any frame it has already started on its own.

## Configuration
- `SWEEP_TIMEOUT_EN` defined: WAIT_BUSY and WAIT_DONE each count cycles. Reaching TIMEOUT sets err[1] and goes to DONE, which pulses `sweep_done`.
- Not defined: both wait states wait indefinitely. err[1] is tied to 0 and the timeout counter is not built.

## Test plan
- One-shot sweep, start=10, stop=14, step=2, dwell=5; bench driver model raises `tx_idle` 40 cycles after the `wrsig` rise and holds it for 1700 cycles. Required: `datain` = 10, 12, 14, with 3 `wrsig` pulses of 128 cycles each, `point_cnt` = 3, one `sweep_done`, `err` = 0.
- Same setup with `cont` = 1. Required: the code sequence after 14 is 10, 12, 14, 10, … ; `stop` mid-DWELL gives IDLE next cycle with no `sweep_done`.
- Config error, start=20, stop=5. Required: no `wrsig`, err = 01, `sweep_done` 2 cycles after `start`.
- Overflow and zero step:
  - start=500, stop=511, step=8: points 500 and 508 only.
  - step=0, stop=start=7: a single point 7, then done.
- With `SWEEP_TIMEOUT_EN` and TIMEOUT=100, `tx_idle` held at 0. Required: err = 10 and `sweep_done` 100 cycles after the `wrsig` fall.
- `rst` pulsed during ASSERT. Required: `wrsig`, `sweep_busy` and `datain` read 0 during `rst`. `start` while busy is ignored, checked by asserting it at the 3rd point with no restart.
